ssd_scan: RTL and testbench

SSD_SCAN -- requirements
Module: ssd_scan

---
 rtl/ssd_pkg.sv | 36 +++
 rtl/ssd_tick_gen.sv | 39 +++
 rtl/ssd_scan.sv | 110 +++++++++++
 tb/tb_ssd_scan.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared constants, types and helpers for the seven-segment scanner
//
// Purpose:
//   Holds the digit count, the all-anodes-off pattern and the slot-select width.
//   Also holds small helpers for nibble select, anode decode and leading-zero tests.
//   The scan rate (DIV) belongs to each instance and is therefore not kept here.
package ssd_pkg;

  localparam int DIGITS = 4;
  localparam int SEL_W  = $clog2(DIGITS);
  localparam int DATA_W = 4 * DIGITS;

  // Anodes are active-low, so every bit high means nothing is lit.
  localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{1'b1}};

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [3:0]        nibble_t;
  typedef logic [DATA_W-1:0] word_t;

  // Nibble shown by slot i; slot DIGITS-1 holds the most significant nibble.
  function automatic nibble_t nib_sel(input word_t v, input sel_t i);
    return v[4*i +: 4];
  endfunction

  // Active-low one-hot anode pattern for slot i.
  function automatic logic [DIGITS-1:0] an_lit(input sel_t i);
    return ~(DIGITS'(1) << i);
  endfunction

  // A slot is a leading zero when it and every more significant nibble are zero.
  // Slot 0 is never treated as leading, so a zero value still shows one "0".
  function automatic logic lz_blank(input word_t v, input sel_t i);
    return (i != '0) && ((v >> (4*i)) == '0);
  endfunction

endpackage

// File: rtl/ssd_tick_gen.sv
// rtl/ssd_tick_gen.sv - free-running prescaler producing one tick every DIV cycles
//
// Purpose:
//   Counts 0..DIV-1 and wraps; tick is high during the cycle whose count is DIV-1.
//   tick is decoded straight from the count flop, so it is glitch-free and
//   carries no path from any input.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous active-low reset; count returns to 0
//   tick   out  one-cycle pulse at the last count of each period
module ssd_tick_gen #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/ssd_scan.sv
// rtl/ssd_scan.sv - multiplexed four-digit hex display scanner with leading-zero blanking
//
// Purpose:
//   Captures a 16-bit value into a shadow register on load.
//   The shadow value moves into the displayed frame only at a frame boundary,
//   which is the tick that takes the slot index from 3 back to 0.
//   Each slot drives the anodes and the current nibble.
//   The first cycle of every slot is dark so the previous digit never ghosts
//   into the new position.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   data_in   in   16-bit value, four hex nibbles
//   load      in   single-cycle capture strobe for data_in
//   blank_lz  in   leading-zero blanking enable, sampled every cycle
//   digit     out  registered nibble of the active slot
//   an        out  registered active-low anode enables
//   busy      out  a captured value is waiting for the next frame boundary
module ssd_scan
  import ssd_pkg::*;
#(
  parameter int DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  input  logic              blank_lz,
  output logic [3:0]        digit,
  output logic [DIGITS-1:0] an,
  output logic              busy
);

  logic tick;

  ssd_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  sel_t              idx_q, idx_d;
  word_t             shadow_q, shadow_d;
  word_t             frame_q, frame_d;
  logic              pending_q, pending_d;
  nibble_t           digit_q, digit_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              wrap;

  always_comb begin
    wrap      = tick && (idx_q == sel_t'(DIGITS - 1));
    idx_d     = tick ? idx_q + 1'b1 : idx_q;
    shadow_d  = shadow_q;
    frame_d   = frame_q;
    pending_d = pending_q;

    // The frame takes the shadow contents held before this edge.
    // A load in the same cycle therefore waits for the following boundary.
    if (wrap && pending_q) begin
      frame_d   = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      shadow_d  = data_in;
      pending_d = 1'b1;
    end
  end

  // Outputs are computed one cycle ahead and registered.
  // The count returns to 0 on the edge that follows a tick, so the anodes
  // are turned off on that same edge, giving the dark cycle at count 0.
  // Outside a tick, idx and frame hold across the edge.
  // Their current values therefore describe the next cycle as well.
  always_comb begin
    digit_d = nib_sel(frame_q, idx_q);
    if (tick) begin
      an_d = AN_OFF;
    end else if (blank_lz && lz_blank(frame_q, idx_q)) begin
      an_d = AN_OFF;
    end else begin
      an_d = an_lit(idx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q     <= '0;
      shadow_q  <= '0;
      frame_q   <= '0;
      pending_q <= 1'b0;
      digit_q   <= '0;
      an_q      <= AN_OFF;
    end else begin
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      frame_q   <= frame_d;
      pending_q <= pending_d;
      digit_q   <= digit_d;
      an_q      <= an_d;
    end
  end

  assign digit = digit_q;
  assign an    = an_q;
  assign busy  = pending_q;

endmodule

// File: tb/tb_ssd_scan.sv
// tb/tb_ssd_scan.sv - directed self-checking bench for ssd_scan with DIV=4
module tb_ssd_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int k = 0;

  ssd_scan #(.DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .load     (load),
    .blank_lz (blank_lz),
    .digit    (digit),
    .an       (an),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // k counts cycles since reset release: cnt = k%4, slot = (k/4)%4.
  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic go_to(input int t);
    while (k < t) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; load = 1'b0; data_in = '0; blank_lz = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    k = 0;
  endtask

  task automatic load_word(input logic [15:0] v);
    data_in = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  function automatic logic [3:0] lit(input int s);
    case (s)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b1; data_in = 16'hFFFF;
    step();
    step();
    n_tests++;
    if (digit !== 4'h0) begin $display("FAIL reset_digit got %h want 0", digit); n_fail++; end
    n_tests++;
    if (an !== 4'b1111) begin $display("FAIL reset_an got %b want 1111", an); n_fail++; end
    n_tests++;
    if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); n_fail++; end
    load = 1'b0; data_in = '0; rst_n = 1'b1; k = 0;
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp_an;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      go_to(c);
      exp_an = (c % 4 == 0) ? 4'b1111 : lit((c / 4) % 4);
      n_tests++;
      if (an !== exp_an) begin $display("FAIL idle_an k=%0d got %b want %b", k, an, exp_an); n_fail++; end
      n_tests++;
      if (digit !== 4'h0) begin $display("FAIL idle_digit k=%0d got %h want 0", k, digit); n_fail++; end
    end
  endtask

  task automatic test_load();
    logic [3:0] ed [4];
    ed = '{4'hB, 4'hA, 4'h2, 4'h1};
    do_reset();
    go_to(5);
    load_word(16'h12AB);
    n_tests++;
    if (busy !== 1'b1) begin $display("FAIL load_busy_set got %b want 1", busy); n_fail++; end
    go_to(15);
    n_tests++;
    if (busy !== 1'b1) begin $display("FAIL load_busy_hold got %b want 1", busy); n_fail++; end
    go_to(16);
    n_tests++;
    if (busy !== 1'b0) begin $display("FAIL load_busy_clear got %b want 0", busy); n_fail++; end
    for (int s = 0; s < 4; s++) begin
      go_to(16 + 4*s + 2);
      n_tests++;
      if (digit !== ed[s]) begin $display("FAIL load_digit slot=%0d got %h want %h", s, digit, ed[s]); n_fail++; end
      n_tests++;
      if (an !== lit(s)) begin $display("FAIL load_an slot=%0d got %b want %b", s, an, lit(s)); n_fail++; end
    end
  endtask

  task automatic test_blank();
    logic [3:0] ed [4];
    logic [3:0] ea [4];
    ed = '{4'h0, 4'hA, 4'h0, 4'h0};
    ea = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    do_reset();
    blank_lz = 1'b1;
    go_to(1);
    load_word(16'h00A0);
    for (int s = 0; s < 4; s++) begin
      go_to(16 + 4*s + 2);
      n_tests++;
      if (an !== ea[s]) begin $display("FAIL blank_an slot=%0d got %b want %b", s, an, ea[s]); n_fail++; end
      n_tests++;
      if (digit !== ed[s]) begin $display("FAIL blank_digit slot=%0d got %h want %h", s, digit, ed[s]); n_fail++; end
    end
  endtask

  task automatic test_zero_blank();
    logic [3:0] ea [4];
    ea = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    do_reset();
    blank_lz = 1'b1;
    go_to(1);
    load_word(16'h0000);
    for (int s = 0; s < 4; s++) begin
      go_to(16 + 4*s + 2);
      n_tests++;
      if (an !== ea[s]) begin $display("FAIL zero_an slot=%0d got %b want %b", s, an, ea[s]); n_fail++; end
      n_tests++;
      if (digit !== 4'h0) begin $display("FAIL zero_digit slot=%0d got %h want 0", s, digit); n_fail++; end
    end
    go_to(37);
    n_tests++;
    if (an !== 4'b1111) begin $display("FAIL zero_pre_toggle got %b want 1111", an); n_fail++; end
    blank_lz = 1'b0;
    step();
    n_tests++;
    if (an !== 4'b1101) begin $display("FAIL zero_toggle_next_edge got %b want 1101", an); n_fail++; end
    go_to(42);
    n_tests++;
    if (an !== 4'b1011) begin $display("FAIL zero_toggle_slot2 got %b want 1011", an); n_fail++; end
    go_to(46);
    n_tests++;
    if (an !== 4'b0111) begin $display("FAIL zero_toggle_slot3 got %b want 0111", an); n_fail++; end
  endtask

  task automatic test_load_on_wrap();
    do_reset();
    go_to(3);
    load_word(16'h2222);
    go_to(15);
    load_word(16'h1111);
    n_tests++;
    if (busy !== 1'b1) begin $display("FAIL wrap_busy_kept got %b want 1", busy); n_fail++; end
    for (int s = 0; s < 4; s++) begin
      go_to(16 + 4*s + 2);
      n_tests++;
      if (digit !== 4'h2) begin $display("FAIL wrap_first_frame slot=%0d got %h want 2", s, digit); n_fail++; end
    end
    go_to(31);
    n_tests++;
    if (busy !== 1'b1) begin $display("FAIL wrap_busy_before got %b want 1", busy); n_fail++; end
    go_to(32);
    n_tests++;
    if (busy !== 1'b0) begin $display("FAIL wrap_busy_after got %b want 0", busy); n_fail++; end
    for (int s = 0; s < 4; s++) begin
      go_to(32 + 4*s + 2);
      n_tests++;
      if (digit !== 4'h1) begin $display("FAIL wrap_second_frame slot=%0d got %h want 1", s, digit); n_fail++; end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ed [4];
    ed = '{4'h8, 4'h7, 4'h6, 4'h5};
    do_reset();
    go_to(2);
    load_word(16'h1234);
    load_word(16'h5678);
    for (int s = 0; s < 4; s++) begin
      go_to(16 + 4*s + 2);
      n_tests++;
      if (digit !== ed[s]) begin $display("FAIL b2b_digit slot=%0d got %h want %h", s, digit, ed[s]); n_fail++; end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    go_to(1);
    load_word(16'hABCD);
    go_to(18);
    n_tests++;
    if (digit !== 4'hD) begin $display("FAIL midrst_pre_digit got %h want d", digit); n_fail++; end
    load_word(16'h5555);
    n_tests++;
    if (busy !== 1'b1) begin $display("FAIL midrst_pending got %b want 1", busy); n_fail++; end
    go_to(21);
    rst_n = 1'b0; load = 1'b1; data_in = 16'hFFFF;
    step();
    n_tests++;
    if (digit !== 4'h0) begin $display("FAIL midrst_digit got %h want 0", digit); n_fail++; end
    n_tests++;
    if (an !== 4'b1111) begin $display("FAIL midrst_an got %b want 1111", an); n_fail++; end
    n_tests++;
    if (busy !== 1'b0) begin $display("FAIL midrst_busy got %b want 0", busy); n_fail++; end
    rst_n = 1'b1; load = 1'b0; data_in = '0; k = 0;
    for (int s = 0; s < 4; s++) begin
      go_to(4*s + 2);
      n_tests++;
      if (an !== lit(s)) begin $display("FAIL midrst_restart_an slot=%0d got %b want %b", s, an, lit(s)); n_fail++; end
    end
    go_to(17);
    n_tests++;
    if (busy !== 1'b0) begin $display("FAIL midrst_busy_later got %b want 0", busy); n_fail++; end
    for (int s = 0; s < 4; s++) begin
      go_to(16 + 4*s + 2);
      n_tests++;
      if (digit !== 4'h0) begin $display("FAIL midrst_discard slot=%0d got %h want 0", s, digit); n_fail++; end
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_load();
    test_blank();
    test_zero_blank();
    test_load_on_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
